// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared combinational 4-bit ALU.
// One operation is in flight at a time: IDLE (grant/accept) -> ISSUE (drive ALU) -> RESP (hold result).
module alu_arbiter_ctrl #(
  parameter logic [2:0] OP_MAX = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic       resp_err,
  output logic [3:0] resp_result,
  output logic       resp_carry,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic       op_id;
  logic       op_err;
  logic [3:0] grant_a;
  logic [3:0] grant_b;
  logic [2:0] grant_sel;

  // With both requesters contending, the one not served last time wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    grant_a   = grant_id ? req1_a   : req0_a;
    grant_b   = grant_id ? req1_b   : req0_b;
    grant_sel = grant_id ? req1_sel : req0_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = RESP;
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Illegal opcodes are still accepted, but the ALU sees a harmless add and the
  // response is forced to zero with the error flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      op_id       <= 1'b0;
      op_err      <= 1'b0;
      alu_a       <= 4'd0;
      alu_b       <= 4'd0;
      alu_sel     <= 3'd0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_err    <= 1'b0;
      resp_result <= 4'd0;
      resp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= grant_a;
            alu_b      <= grant_b;
            alu_sel    <= (grant_sel > OP_MAX) ? 3'd0 : grant_sel;
            op_err     <= (grant_sel > OP_MAX);
            op_id      <= grant_id;
            last_grant <= grant_id;
          end
        end
        ISSUE: begin
          resp_valid  <= 1'b1;
          resp_id     <= op_id;
          resp_err    <= op_err;
          resp_result <= op_err ? 4'd0 : alu_result;
          resp_carry  <= op_err ? 1'b0 : alu_carry;
          alu_a       <= 4'd0;
          alu_b       <= 4'd0;
          alu_sel     <= 3'd0;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_err    <= 1'b0;
            resp_result <= 4'd0;
            resp_carry  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: behavioural ALU, vector table,
// response scoreboard and hand-written contention/backpressure/reset sequences.
module tb_alu_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry;
  logic       resp_valid, resp_ready, resp_id, resp_err, resp_carry, busy;
  logic [3:0] resp_result;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct packed {
    logic       id;
    logic       err;
    logic       carry;
    logic [3:0] res;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] res;
    logic       carry;
    logic       err;
    int         stall;
  } vec_t;
  vec_t vecs[9];

  alu_arbiter_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_err(resp_err),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU; subtract reports borrow in the carry bit.
  always_comb begin
    {alu_carry, alu_result} = 5'd0;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic id, input logic v, input logic [3:0] a,
                               input logic [3:0] b, input logic [2:0] sel);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  // Scoreboard: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", {25'd0, resp_id, resp_err, resp_carry, resp_result}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("resp", {25'd0, resp_id, resp_err, resp_carry, resp_result}, {25'd0, e});
      end
    end
  end

  // Single-requester operation, starting and ending just after a rising edge in IDLE.
  task automatic run_op(input vec_t v);
    logic [2:0] exp_sel;
    exp_sel = v.err ? 3'd0 : v.sel;
    resp_ready = 1'b0;
    applyStimulus(v.id, 1'b1, v.a, v.b, v.sel);
    @(negedge clk);
    checkOutput("grant", {busy, req0_ready, req1_ready}, {1'b0, ~v.id, v.id});
    exp_q.push_back({v.id, v.err, v.carry, v.res});
    tick();
    applyStimulus(v.id, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    checkOutput("issue_ctl", {resp_valid, busy, req0_ready, req1_ready}, 4'b0100);
    checkOutput("issue_alu", {alu_a, alu_b, alu_sel}, {v.a, v.b, exp_sel});
    tick();
    @(negedge clk);
    checkOutput("latency", resp_valid, 1'b1);
    for (int s = 0; s < v.stall; s++) begin
      tick();
      @(negedge clk);
      checkOutput("stall_hold",
        {resp_valid, busy, req0_ready, req1_ready, resp_id, resp_err, resp_carry, resp_result},
        {4'b1100, v.id, v.err, v.carry, v.res});
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("release", {resp_valid, busy, alu_sel}, 5'd0);
    checkOutput("drain", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           id    a        b        sel     res      c     e     stall
    vecs[0] = '{1'b0, 4'b1010, 4'b0101, 3'b000, 4'b1111, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 4'b1010, 4'b0101, 3'b001, 4'b0101, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 4'b1010, 4'b0101, 3'b010, 4'b0000, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 4'b1010, 4'b0101, 3'b011, 4'b1111, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b0, 4'b0011, 4'b0101, 3'b001, 4'b1110, 1'b1, 1'b0, 0};
    vecs[6] = '{1'b1, 4'b1010, 4'b0101, 3'b110, 4'b0000, 1'b0, 1'b1, 0};
    vecs[7] = '{1'b0, 4'b1111, 4'b0001, 3'b111, 4'b0000, 1'b0, 1'b1, 0};
    vecs[8] = '{1'b0, 4'b0110, 4'b0011, 3'b100, 4'b0101, 1'b0, 1'b0, 5};

    rst = 1'b1;
    resp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_outputs",
      {req0_ready, req1_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_err, resp_result, resp_carry, busy},
      32'd0);

    // Contention straight out of reset: req0, req1, req0, req1 at one op per 3 cycles.
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b1010, 4'b0101, 3'b000);
    applyStimulus(1'b1, 1'b1, 4'b1010, 4'b0101, 3'b100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      exp_q.push_back({(k % 2 == 1), 1'b0, 1'b0, 4'b1111});
      tick();
      @(negedge clk);
      checkOutput("rr_issue", {busy, alu_sel}, (k % 2 == 0) ? 4'b1000 : 4'b1100);
      tick();
      @(negedge clk);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    checkOutput("rr_drain", {busy, 8'(exp_q.size())}, 9'd0);
    tick();

    // resp_ready while idle must not disturb anything.
    @(negedge clk);
    checkOutput("idle_ready_noeffect", {resp_valid, busy}, 2'b00);
    tick();
    resp_ready = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset while a response is held: it is discarded and a new request goes straight in.
    applyStimulus(1'b1, 1'b1, 4'b1010, 4'b0101, 3'b011);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    @(negedge clk);
    checkOutput("pre_reset_resp", resp_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b1100, 4'b1010, 3'b010);
    @(negedge clk);
    checkOutput("post_reset", {resp_valid, busy, req0_ready}, 3'b001);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b1000});
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    checkOutput("post_reset_issue", {resp_valid, busy}, 2'b01);
    tick();
    @(negedge clk);
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_drain", {busy, resp_valid, 8'(exp_q.size())}, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
